// File: rtl/div_xxbit_restore_pkg.sv
// Shared definitions for the restoring divider: FSM encoding and counter sizing.
package div_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // The iteration counter must be able to hold DATA_WIDTH-1.
  function automatic int cnt_width(input int data_width);
    return $clog2(data_width) + 1;
  endfunction

endpackage

// File: rtl/div_xxbit_restore.sv
// Radix-2 restoring integer divider, one quotient bit per clock, start/end handshake.
// Handshake: i_start is accepted only in IDLE; o_end pulses for one cycle with results valid.
module div_xxbit_restore
  import div_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter bit SIGNED     = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_num_a,
  input  logic [DATA_WIDTH-1:0] i_num_b,
  output logic                  o_busy,
  output logic                  o_end,
  output logic [DATA_WIDTH-1:0] o_quo,
  output logic [DATA_WIDTH-1:0] o_rem,
  output logic                  o_dzero
);

  localparam int CW = cnt_width(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  div_state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] dividend_q;
  logic [DATA_WIDTH-1:0] divisor_q;
  logic [DATA_WIDTH-1:0] rem_q;
  logic [DATA_WIDTH-1:0] quo_q;
  logic [CW-1:0]         cnt_q;
  logic                  neg_q_q;
  logic                  neg_r_q;
  logic                  dz_q;

  logic [DATA_WIDTH-1:0] quo_out_q;
  logic [DATA_WIDTH-1:0] rem_out_q;
  logic                  dz_out_q;
  logic                  end_q;

  logic                  sign_a;
  logic                  sign_b;
  logic [DATA_WIDTH-1:0] abs_a;
  logic [DATA_WIDTH-1:0] abs_b;
  logic                  b_zero;

  logic [DATA_WIDTH:0]   rem_sh;
  logic [DATA_WIDTH-1:0] quo_sh;
  logic [DATA_WIDTH:0]   trial;
  logic                  trial_neg;

  // Magnitudes are unsigned N-bit values, so |MIN| becomes 2^(N-1) without overflow.
  always_comb begin
    sign_a = SIGNED ? i_num_a[DATA_WIDTH-1] : 1'b0;
    sign_b = SIGNED ? i_num_b[DATA_WIDTH-1] : 1'b0;
    abs_a  = sign_a ? -i_num_a : i_num_a;
    abs_b  = sign_b ? -i_num_b : i_num_b;
    b_zero = (i_num_b == '0);
  end

  // Shift {rem,quo} left and subtract; the extra top bit of trial is its sign.
  always_comb begin
    rem_sh    = {rem_q, quo_q[DATA_WIDTH-1]};
    quo_sh    = {quo_q[DATA_WIDTH-2:0], 1'b0};
    trial     = rem_sh - {1'b0, divisor_q};
    trial_neg = trial[DATA_WIDTH];
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= DIV_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DIV_IDLE: begin
        if (i_start) begin
          state_d = b_zero ? DIV_DONE : DIV_CALC;
        end
      end
      DIV_CALC: begin
        if (cnt_q == LAST_CNT) begin
          state_d = DIV_DONE;
        end
      end
      DIV_DONE: begin
        state_d = DIV_IDLE;
      end
      default: begin
        state_d = DIV_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      dividend_q <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      dz_q       <= 1'b0;
      quo_out_q  <= '0;
      rem_out_q  <= '0;
      dz_out_q   <= 1'b0;
      end_q      <= 1'b0;
    end else begin
      end_q <= 1'b0;
      case (state_q)
        DIV_IDLE: begin
          if (i_start) begin
            dividend_q <= i_num_a;
            dz_q       <= b_zero;
            divisor_q  <= abs_b;
            quo_q      <= abs_a;
            rem_q      <= '0;
            cnt_q      <= '0;
            neg_q_q    <= sign_a ^ sign_b;
            neg_r_q    <= sign_a;
          end
        end
        DIV_CALC: begin
          rem_q <= trial_neg ? rem_sh[DATA_WIDTH-1:0] : trial[DATA_WIDTH-1:0];
          quo_q <= {quo_sh[DATA_WIDTH-1:1], ~trial_neg};
          cnt_q <= cnt_q + CNT_ONE;
        end
        DIV_DONE: begin
          end_q <= 1'b1;
          if (dz_q) begin
            quo_out_q <= '1;
            rem_out_q <= dividend_q;
            dz_out_q  <= 1'b1;
          end else begin
            quo_out_q <= neg_q_q ? -quo_q : quo_q;
            rem_out_q <= neg_r_q ? -rem_q : rem_q;
            dz_out_q  <= 1'b0;
          end
        end
        default: begin
          end_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy  = (state_q == DIV_CALC) || (state_q == DIV_DONE);
  assign o_end   = end_q;
  assign o_quo   = quo_out_q;
  assign o_rem   = rem_out_q;
  assign o_dzero = dz_out_q;

endmodule

// File: tb/tb_div_xxbit_restore.sv
// Bench for the restoring divider: a signed and an unsigned instance checked against
// a plain-arithmetic reference for quotient, remainder, divide-by-zero and timing.
module tb_div_xxbit_restore;

  localparam int N = 8;

  logic         clk;
  logic         rst_n;
  logic         start_s, start_u;
  logic [N-1:0] a_s, b_s, a_u, b_u;
  logic         busy_s, end_s, dz_s;
  logic         busy_u, end_u, dz_u;
  logic [N-1:0] quo_s, rem_s, quo_u, rem_u;

  int checks = 0;
  int errors = 0;

  logic [2*N:0] exp_q[$];

  div_xxbit_restore #(.DATA_WIDTH(N), .SIGNED(1'b1)) dut_s (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_s), .i_num_a(a_s), .i_num_b(b_s),
    .o_busy(busy_s), .o_end(end_s), .o_quo(quo_s), .o_rem(rem_s), .o_dzero(dz_s)
  );

  div_xxbit_restore #(.DATA_WIDTH(N), .SIGNED(1'b0)) dut_u (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_u), .i_num_a(a_u), .i_num_b(b_u),
    .o_busy(busy_u), .o_end(end_u), .o_quo(quo_u), .o_rem(rem_u), .o_dzero(dz_u)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

  // Reference: truncating division via the language's own / and %, packed {dz,q,r}.
  function automatic logic [2*N:0] ref_div(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input bit sgn);
    int sa, sb;
    logic [N-1:0] q, r;
    if (b == '0) return {1'b1, {N{1'b1}}, a};
    if (sgn) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
      q  = N'(sa / sb);
      r  = N'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {1'b0, q, r};
  endfunction

  function automatic logic [2*N:0] observed(input bit sel);
    return sel ? {dz_s, quo_s, rem_s} : {dz_u, quo_u, rem_u};
  endfunction

  // Driver: one operation, checks latency, results and the single-cycle end pulse.
  task automatic do_op(input bit sel, input logic [N-1:0] a, input logic [N-1:0] b,
                       input string name);
    int lat, exp_lat;
    logic [2*N:0] exp, got;
    exp_q.push_back(ref_div(a, b, sel));
    @(negedge clk);
    if (sel) begin start_s = 1'b1; a_s = a; b_s = b; end
    else     begin start_u = 1'b1; a_u = a; b_u = b; end
    @(posedge clk); #1;
    start_s = 1'b0;
    start_u = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (sel ? end_s : end_u) begin
        lat = k;
        break;
      end
    end
    exp     = exp_q.pop_front();
    exp_lat = exp[2*N] ? 1 : N + 1;
    got     = observed(sel);
    checks++;
    if (lat !== exp_lat) begin
      errors++;
      $display("FAIL %s latency got %0d exp %0d", name, lat, exp_lat);
    end
    checks++;
    if (got[2*N-1:N] !== exp[2*N-1:N]) begin
      errors++;
      $display("FAIL %s quo a=%h b=%h got %h exp %h", name, a, b, got[2*N-1:N], exp[2*N-1:N]);
    end
    checks++;
    if (got[N-1:0] !== exp[N-1:0]) begin
      errors++;
      $display("FAIL %s rem a=%h b=%h got %h exp %h", name, a, b, got[N-1:0], exp[N-1:0]);
    end
    checks++;
    if (got[2*N] !== exp[2*N]) begin
      errors++;
      $display("FAIL %s dzero got %b exp %b", name, got[2*N], exp[2*N]);
    end
    @(posedge clk); #1;
    checks++;
    if ((sel ? end_s : end_u) !== 1'b0) begin
      errors++;
      $display("FAIL %s end_width got 1 exp 0", name);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start_s = 1'b0; start_u = 1'b0;
    a_s = '0; b_s = '0; a_u = '0; b_u = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy_s, end_s, dz_s, quo_s, rem_s} !== '0) begin
      errors++;
      $display("FAIL reset_signed got %h exp 0", {busy_s, end_s, dz_s, quo_s, rem_s});
    end
    checks++;
    if ({busy_u, end_u, dz_u, quo_u, rem_u} !== '0) begin
      errors++;
      $display("FAIL reset_unsigned got %h exp 0", {busy_u, end_u, dz_u, quo_u, rem_u});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_signed_directed();
    do_op(1'b1, 8'd100, 8'd7, "s_100_7");
    do_op(1'b1, 8'h9C, 8'd7, "s_m100_7");
    do_op(1'b1, 8'd100, 8'hF9, "s_100_m7");
    do_op(1'b1, 8'd7, 8'd0, "s_dzero");
    do_op(1'b1, 8'h80, 8'hFF, "s_min_m1");
    do_op(1'b1, 8'h80, 8'h01, "s_min_1");
  endtask

  task automatic test_unsigned_directed();
    do_op(1'b0, 8'd200, 8'd3, "u_200_3");
    do_op(1'b0, 8'd5, 8'd9, "u_5_9");
    do_op(1'b0, 8'hFF, 8'hFF, "u_max_max");
    do_op(1'b0, 8'hFF, 8'd0, "u_dzero");
  endtask

  task automatic test_random();
    logic [N-1:0] a, b;
    for (int i = 0; i < 40; i++) begin
      a = N'($urandom);
      b = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
      if ($urandom_range(0, 9) == 0) a = 8'h80;
      do_op(i[0], a, b, i[0] ? "rand_s" : "rand_u");
    end
  endtask

  // Start held high: every result is followed by an immediate accept.
  task automatic test_back_to_back();
    int ends_k[$];
    int consec;
    logic prev;
    bit drained;
    @(negedge clk);
    start_u = 1'b1; a_u = 8'd200; b_u = 8'd3;
    @(posedge clk); #1;
    prev = 1'b0;
    consec = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (end_u) begin
        ends_k.push_back(k);
        checks++;
        if ({quo_u, rem_u} !== {8'd66, 8'd2}) begin
          errors++;
          $display("FAIL b2b_result got %h exp %h", {quo_u, rem_u}, {8'd66, 8'd2});
        end
        if (prev) consec++;
      end
      prev = end_u;
    end
    start_u = 1'b0;
    checks++;
    if (ends_k.size() !== 3) begin
      errors++;
      $display("FAIL b2b_count got %0d exp 3", ends_k.size());
    end
    for (int i = 0; i < ends_k.size(); i++) begin
      checks++;
      if (ends_k[i] !== 9 + 10 * i) begin
        errors++;
        $display("FAIL b2b_spacing got %0d exp %0d", ends_k[i], 9 + 10 * i);
      end
    end
    checks++;
    if (consec !== 0) begin
      errors++;
      $display("FAIL b2b_double_end got %0d exp 0", consec);
    end
    drained = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (end_u) begin
        drained = 1'b1;
        break;
      end
    end
    checks++;
    if (drained !== 1'b1) begin
      errors++;
      $display("FAIL b2b_drain got 0 exp 1");
    end
  endtask

  // Operand changes and start pulses while busy must not disturb the running divide.
  task automatic test_busy_ignore();
    int lat, extra;
    @(negedge clk);
    start_u = 1'b1; a_u = 8'd200; b_u = 8'd3;
    @(posedge clk); #1;
    start_u = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k >= 2 && k <= 5) begin start_u = 1'b1; a_u = 8'd1; b_u = 8'd1; end
      else start_u = 1'b0;
      @(posedge clk); #1;
      if (end_u) begin
        lat = k;
        break;
      end
    end
    start_u = 1'b0;
    checks++;
    if (lat !== 9) begin
      errors++;
      $display("FAIL busy_latency got %0d exp 9", lat);
    end
    checks++;
    if ({quo_u, rem_u} !== {8'd66, 8'd2}) begin
      errors++;
      $display("FAIL busy_result got %h exp %h", {quo_u, rem_u}, {8'd66, 8'd2});
    end
    extra = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (end_u) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL busy_spurious_end got %0d exp 0", extra);
    end
  endtask

  task automatic test_reset_mid();
    int extra;
    @(negedge clk);
    start_u = 1'b1; a_u = 8'd200; b_u = 8'd3;
    @(posedge clk); #1;
    start_u = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if ({busy_u, end_u, dz_u, quo_u, rem_u} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got %h exp 0", {busy_u, end_u, dz_u, quo_u, rem_u});
    end
    extra = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (end_u || busy_u) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL midreset_activity got %0d exp 0", extra);
    end
    do_op(1'b0, 8'd50, 8'd5, "u_after_reset");
  endtask

  initial begin
    test_reset();
    test_signed_directed();
    test_unsigned_directed();
    test_random();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
